// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps a 4-input function through all 16 input combinations and captures its truth table.
// Optional macro SCAN_SETTLE_EN: each index gets one settle cycle before the sampling cycle.
module truth_table_scanner #(
   parameter bit SWEEP_DOWN = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_s,
   output logic        o_x,
   output logic        o_y,
   output logic        o_w,
   output logic        o_z,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_table,
   output logic [4:0]  o_ones
);

`ifdef SCAN_SETTLE_EN
   localparam bit SETTLE = 1'b1;
`else
   localparam bit SETTLE = 1'b0;
`endif

   localparam logic [3:0] FIRST_IDX = SWEEP_DOWN ? 4'hF : 4'h0;
   localparam logic [3:0] LAST_IDX  = SWEEP_DOWN ? 4'h0 : 4'hF;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      r_state;
   logic [3:0]  r_index;
   logic        r_phase;
   logic        r_busy;
   logic        r_done;
   logic [15:0] r_table;
   logic [4:0]  r_ones;
   logic        w_sample;

   // Without settling every RUN cycle samples; with it only the second cycle of each index does.
   assign w_sample = !SETTLE || r_phase;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_index <= 4'h0;
         r_phase <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_table <= 16'h0000;
         r_ones  <= 5'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_table <= 16'h0000;
                  r_ones  <= 5'd0;
                  r_index <= FIRST_IDX;
                  r_phase <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (w_sample) begin
                  r_table[r_index] <= i_s;
                  r_ones           <= r_ones + {4'd0, i_s};
                  // The index parks on the last value so the outputs hold it afterwards.
                  if (r_index == LAST_IDX) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_index <= SWEEP_DOWN ? r_index - 4'd1 : r_index + 4'd1;
                  end
               end
               r_phase <= SETTLE & ~r_phase;
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign {o_x, o_y, o_w, o_z} = r_index;
   assign o_busy  = r_busy;
   assign o_done  = r_done;
   assign o_table = r_table;
   assign o_ones  = r_ones;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: an up-sweeping and a down-sweeping instance, each driven by a selectable function.
module tb_truth_table_scanner;

`ifdef SCAN_SETTLE_EN
   localparam int CPI = 2;
`else
   localparam int CPI = 1;
`endif
   localparam int N_RUN = 16 * CPI;
   localparam int WIN   = N_RUN + 6;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_up = 1'b0, start_dn = 1'b0;
   logic        s_up, s_dn;
   logic        xu, yu, wu, zu, xd, yd, wd, zd;
   logic        busy_up, done_up, busy_dn, done_dn;
   logic [15:0] tbl_up, tbl_dn;
   logic [4:0]  ones_up, ones_dn;
   int          kind_up = 0, kind_dn = 0;
   logic [15:0] rlut_up = 16'h0, rlut_dn = 16'h0;
   int          n_total = 0, n_pass = 0;

   always #5 clk = ~clk;

   // Function under test: 0 const0, 1 const1, 2 team PoS function, 3 s=x, other = random lookup.
   function automatic logic fut(input int kind, input logic [15:0] rl, input logic [3:0] m);
      case (kind)
         0: return 1'b0;
         1: return 1'b1;
         2: return (m == 4'd2) || (m == 4'd4) || (m == 4'd7) || (m == 4'd11) || (m == 4'd12);
         3: return m[3];
         default: return rl[m];
      endcase
   endfunction

   function automatic logic [15:0] ref_table(input int kind, input logic [15:0] rl);
      logic [15:0] t;
      t = 16'h0;
      for (int m = 0; m < 16; m++) t[m] = fut(kind, rl, 4'(m));
      return t;
   endfunction

   function automatic int ref_ones(input int kind, input logic [15:0] rl);
      int n;
      n = 0;
      for (int m = 0; m < 16; m++) if (fut(kind, rl, 4'(m))) n++;
      return n;
   endfunction

   assign s_up = fut(kind_up, rlut_up, {xu, yu, wu, zu});
   assign s_dn = fut(kind_dn, rlut_dn, {xd, yd, wd, zd});

   truth_table_scanner #(.SWEEP_DOWN(1'b0)) u_up (
      .i_clk(clk), .i_reset(rst), .i_start(start_up), .i_s(s_up),
      .o_x(xu), .o_y(yu), .o_w(wu), .o_z(zu),
      .o_busy(busy_up), .o_done(done_up), .o_table(tbl_up), .o_ones(ones_up)
   );

   truth_table_scanner #(.SWEEP_DOWN(1'b1)) u_dn (
      .i_clk(clk), .i_reset(rst), .i_start(start_dn), .i_s(s_dn),
      .o_x(xd), .o_y(yd), .o_w(wd), .o_z(zd),
      .o_busy(busy_dn), .o_done(done_dn), .o_table(tbl_dn), .o_ones(ones_dn)
   );

   // Runs one sweep on the chosen instance and returns what was observed over a fixed window.
   task automatic sweep(input bit dn, input bit hold, output int done_cyc, output int busy_cyc,
                        output int pulses, output int overlap, output logic [3:0] first_idx,
                        output logic [15:0] tbl, output logic [4:0] ones);
      logic b, d;
      done_cyc = 0; busy_cyc = 0; pulses = 0; overlap = 0;
      @(posedge clk); #1;
      if (dn) start_dn = 1'b1; else start_up = 1'b1;
      @(posedge clk); #1;
      if (!hold) begin start_up = 1'b0; start_dn = 1'b0; end
      first_idx = dn ? {xd, yd, wd, zd} : {xu, yu, wu, zu};
      for (int c = 1; c <= WIN; c++) begin
         b = dn ? busy_dn : busy_up;
         d = dn ? done_dn : done_up;
         if (b) busy_cyc++;
         if (d) begin pulses++; if (done_cyc == 0) done_cyc = c; end
         if (b && d) overlap++;
         if (c == N_RUN + 2) begin start_up = 1'b0; start_dn = 1'b0; end
         if (c < WIN) begin @(posedge clk); #1; end
      end
      tbl  = dn ? tbl_dn : tbl_up;
      ones = dn ? ones_dn : ones_up;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      n_total++; if (busy_up !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_up); else n_pass++;
      n_total++; if (done_up !== 1'b0) $display("FAIL reset_done: got %b want 0", done_up); else n_pass++;
      n_total++; if (tbl_up !== 16'h0) $display("FAIL reset_table: got %h want 0000", tbl_up); else n_pass++;
      n_total++; if (ones_up !== 5'd0) $display("FAIL reset_ones: got %0d want 0", ones_up); else n_pass++;
      n_total++; if ({xd, yd, wd, zd} !== 4'h0) $display("FAIL reset_idx: got %h want 0", {xd, yd, wd, zd}); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      $display("reset: busy=%b done=%b table=%h ones=%0d", busy_up, done_up, tbl_up, ones_up);
   endtask

   task automatic test_zero();
      int dc, bc, p, ov; logic [3:0] fi; logic [15:0] t; logic [4:0] o;
      kind_up = 0;
      sweep(1'b0, 1'b0, dc, bc, p, ov, fi, t, o);
      $display("zero: done_cyc=%0d busy=%0d table=%h ones=%0d", dc, bc, t, o);
      n_total++; if (dc !== N_RUN + 1) $display("FAIL zero_done_cycle: got %0d want %0d", dc, N_RUN + 1); else n_pass++;
      n_total++; if (bc !== N_RUN) $display("FAIL zero_busy_cycles: got %0d want %0d", bc, N_RUN); else n_pass++;
      n_total++; if (t !== 16'h0000) $display("FAIL zero_table: got %h want 0000", t); else n_pass++;
      n_total++; if (o !== 5'd0) $display("FAIL zero_ones: got %0d want 0", o); else n_pass++;
   endtask

   task automatic test_one();
      int dc, bc, p, ov; logic [3:0] fi; logic [15:0] t; logic [4:0] o;
      kind_up = 1;
      sweep(1'b0, 1'b0, dc, bc, p, ov, fi, t, o);
      $display("one: done_cyc=%0d pulses=%0d table=%h ones=%0d", dc, p, t, o);
      n_total++; if (t !== 16'hFFFF) $display("FAIL one_table: got %h want ffff", t); else n_pass++;
      n_total++; if (o !== 5'd16) $display("FAIL one_ones: got %0d want 16", o); else n_pass++;
      n_total++; if (p !== 1) $display("FAIL one_pulses: got %0d want 1", p); else n_pass++;
      n_total++; if (ov !== 0) $display("FAIL one_busy_done_overlap: got %0d want 0", ov); else n_pass++;
      n_total++; if ({xu, yu, wu, zu} !== 4'hF) $display("FAIL one_idle_idx_hold: got %h want f", {xu, yu, wu, zu}); else n_pass++;
   endtask

   task automatic test_pos();
      int dc, bc, p, ov; logic [3:0] fi; logic [15:0] t; logic [4:0] o;
      kind_up = 2;
      sweep(1'b0, 1'b0, dc, bc, p, ov, fi, t, o);
      $display("pos_up: first=%h table=%h ones=%0d", fi, t, o);
      n_total++; if (t !== 16'h1894) $display("FAIL pos_up_table: got %h want 1894", t); else n_pass++;
      n_total++; if (o !== 5'd5) $display("FAIL pos_up_ones: got %0d want 5", o); else n_pass++;
      n_total++; if (fi !== 4'h0) $display("FAIL pos_up_first_idx: got %h want 0", fi); else n_pass++;
      kind_dn = 2;
      sweep(1'b1, 1'b0, dc, bc, p, ov, fi, t, o);
      $display("pos_down: first=%h done_cyc=%0d table=%h ones=%0d", fi, dc, t, o);
      n_total++; if (t !== 16'h1894) $display("FAIL pos_dn_table: got %h want 1894", t); else n_pass++;
      n_total++; if (o !== 5'd5) $display("FAIL pos_dn_ones: got %0d want 5", o); else n_pass++;
      n_total++; if (fi !== 4'hF) $display("FAIL pos_dn_first_idx: got %h want f", fi); else n_pass++;
      n_total++; if (dc !== N_RUN + 1) $display("FAIL pos_dn_done_cycle: got %0d want %0d", dc, N_RUN + 1); else n_pass++;
      n_total++; if ({xd, yd, wd, zd} !== 4'h0) $display("FAIL pos_dn_idle_idx_hold: got %h want 0", {xd, yd, wd, zd}); else n_pass++;
   endtask

   task automatic test_x();
      int dc, bc, p, ov; logic [3:0] fi; logic [15:0] t; logic [4:0] o;
      kind_up = 3;
      sweep(1'b0, 1'b0, dc, bc, p, ov, fi, t, o);
      $display("s_eq_x: done_cyc=%0d busy=%0d table=%h ones=%0d", dc, bc, t, o);
      n_total++; if (t !== 16'hFF00) $display("FAIL x_table: got %h want ff00", t); else n_pass++;
      n_total++; if (o !== 5'd8) $display("FAIL x_ones: got %0d want 8", o); else n_pass++;
      n_total++; if (dc !== N_RUN + 1) $display("FAIL x_done_cycle: got %0d want %0d", dc, N_RUN + 1); else n_pass++;
      n_total++; if (bc !== N_RUN) $display("FAIL x_busy_cycles: got %0d want %0d", bc, N_RUN); else n_pass++;
   endtask

   task automatic test_random();
      int dc, bc, p, ov; logic [3:0] fi; logic [15:0] t; logic [4:0] o;
      logic [15:0] et; int eo; bit dn;
      for (int i = 0; i < 6; i++) begin
         dn = i[0];
         if (dn) begin kind_dn = 9; rlut_dn = 16'($urandom); et = ref_table(kind_dn, rlut_dn); eo = ref_ones(kind_dn, rlut_dn); end
         else begin kind_up = 9; rlut_up = 16'($urandom); et = ref_table(kind_up, rlut_up); eo = ref_ones(kind_up, rlut_up); end
         sweep(dn, 1'b0, dc, bc, p, ov, fi, t, o);
         $display("random[%0d] dn=%0d: table=%h want %h ones=%0d want %0d", i, dn, t, et, o, eo);
         n_total++; if (t !== et) $display("FAIL rand_table[%0d]: got %h want %h", i, t, et); else n_pass++;
         n_total++; if (int'(o) !== eo) $display("FAIL rand_ones[%0d]: got %0d want %0d", i, o, eo); else n_pass++;
         n_total++; if (p !== 1) $display("FAIL rand_pulses[%0d]: got %0d want 1", i, p); else n_pass++;
      end
   endtask

   task automatic test_reset_abort();
      int seen_done, dc;
      kind_up = 1;
      @(posedge clk); #1; start_up = 1'b1;
      @(posedge clk); #1; start_up = 1'b0;
      for (int c = 2; c <= 5; c++) begin @(posedge clk); #1; end
      n_total++; if (busy_up !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy_up); else n_pass++;
      rst = 1'b1;
      #1;
      $display("abort: busy=%b done=%b table=%h ones=%0d idx=%h", busy_up, done_up, tbl_up, ones_up, {xu, yu, wu, zu});
      n_total++; if (busy_up !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy_up); else n_pass++;
      n_total++; if (tbl_up !== 16'h0) $display("FAIL abort_table: got %h want 0000", tbl_up); else n_pass++;
      n_total++; if (ones_up !== 5'd0) $display("FAIL abort_ones: got %0d want 0", ones_up); else n_pass++;
      n_total++; if ({xu, yu, wu, zu} !== 4'h0) $display("FAIL abort_idx: got %h want 0", {xu, yu, wu, zu}); else n_pass++;
      seen_done = 0;
      for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (done_up) seen_done++; end
      rst = 1'b0;
      start_up = 1'b1;
      @(posedge clk); #1;
      start_up = 1'b0;
      n_total++; if (busy_up !== 1'b1) $display("FAIL restart_accept: got busy %b want 1", busy_up); else n_pass++;
      dc = 0;
      for (int c = 1; c <= WIN; c++) begin
         if (done_up) begin seen_done++; if (dc == 0) dc = c; end
         if (c < WIN) begin @(posedge clk); #1; end
      end
      $display("restart: done_cyc=%0d pulses=%0d table=%h ones=%0d", dc, seen_done, tbl_up, ones_up);
      n_total++; if (seen_done !== 1) $display("FAIL abort_done_pulses: got %0d want 1", seen_done); else n_pass++;
      n_total++; if (dc !== N_RUN + 1) $display("FAIL restart_done_cycle: got %0d want %0d", dc, N_RUN + 1); else n_pass++;
      n_total++; if (tbl_up !== 16'hFFFF) $display("FAIL restart_table: got %h want ffff", tbl_up); else n_pass++;
   endtask

   task automatic test_start_held();
      int dc, bc, p, ov; logic [3:0] fi; logic [15:0] t; logic [4:0] o; logic [15:0] et;
      kind_up = 9; rlut_up = 16'($urandom); et = ref_table(kind_up, rlut_up);
      sweep(1'b0, 1'b1, dc, bc, p, ov, fi, t, o);
      $display("start_held: pulses=%0d busy=%0d table=%h", p, bc, t);
      n_total++; if (p !== 1) $display("FAIL held_pulses: got %0d want 1", p); else n_pass++;
      n_total++; if (bc !== N_RUN) $display("FAIL held_busy_cycles: got %0d want %0d", bc, N_RUN); else n_pass++;
      n_total++; if (t !== et) $display("FAIL held_table: got %h want %h", t, et); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int dc, bc, p, ov; logic [3:0] fi; logic [15:0] t; logic [4:0] o; logic [15:0] et;
      for (int i = 0; i < 2; i++) begin
         kind_dn = 9; rlut_dn = 16'($urandom); et = ref_table(kind_dn, rlut_dn);
         sweep(1'b1, 1'b0, dc, bc, p, ov, fi, t, o);
         $display("back_to_back[%0d]: first=%h table=%h want %h", i, fi, t, et);
         n_total++; if (t !== et) $display("FAIL b2b_table[%0d]: got %h want %h", i, t, et); else n_pass++;
         n_total++; if (fi !== 4'hF) $display("FAIL b2b_first_idx[%0d]: got %h want f", i, fi); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_one();
      test_pos();
      test_x();
      test_random();
      test_reset_abort();
      test_start_held();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter SWEEP_DOWN, default 0; 0 = sweep index 0->15, 1 = sweep index 15->0.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a full 16-combination sweep; sampled only in IDLE.
REQ-005 x, y, w, z  output  1 each  drive inputs of the 4-input function under test; {x,y,w,z} = current index, x = MSB.
REQ-006 s  input  1  function-under-test output; combinational response to x,y,w,z.
REQ-007 busy  output  1  high while a sweep is in progress (RUN state).
REQ-008 done  output  1  one-cycle pulse after the 16th sample.
REQ-009 table  output  16  captured truth table; bit M = s observed with {x,y,w,z} = M.
REQ-010 ones  output  5  count of 1s captured in table, 0..16.

Function
REQ-011 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-012 IDLE: start=1 at a clock edge -> clear table and ones to 0, load index (0, or 15 if SWEEP_DOWN=1), enter RUN.
REQ-013 RUN: {x,y,w,z} driven from a registered index; no combinational path from s or start to any output.
REQ-014 RUN, one sample per index: at the sampling edge, table[index] <= s, ones <= ones + s, then index +1 (or -1 if SWEEP_DOWN=1).
REQ-015 After the sample for the last index (15, or 0 if SWEEP_DOWN=1), enter DONE; the index does not wrap.
REQ-016 DONE lasts exactly one cycle with done=1, then returns to IDLE.
REQ-017 Latency, macro undefined: start edge at cycle 0; RUN cycles 1..16; done=1 in cycle 17.
REQ-018 busy=1 only in RUN; done=1 only in DONE; never both high together.
REQ-019 start while in RUN or DONE is ignored; no restart, no queuing.
REQ-020 table and ones hold their values from DONE until the next accepted start.
REQ-021 In IDLE and DONE, {x,y,w,z} hold the last driven value.
REQ-022 ones never exceeds 16; the 5-bit width is sufficient and no saturation logic is required.

Reset
REQ-023 Reset forces IDLE, busy=0, done=0, table=0, ones=0, {x,y,w,z}=0000 immediately, independent of clk.
REQ-024 Reset during RUN aborts the sweep: no done pulse is issued and partial results are discarded.
REQ-025 start sampled high on the first edge after reset deassertion is accepted normally.

Configuration
REQ-026 Macro SCAN_SETTLE_EN: when defined, each index occupies 2 RUN cycles.
REQ-027 With SCAN_SETTLE_EN, the first cycle only drives the index (settle) and the second cycle samples s at its closing edge; RUN lasts 32 cycles and done=1 in cycle 33.
REQ-028 Without SCAN_SETTLE_EN, the behaviour is exactly as in REQ-014 to REQ-017; captured table values are identical in both builds for a combinational s.

Verification
REQ-029 s tied 0, start pulse -> done in cycle 17, table=0x0000, ones=0.
REQ-030 s tied 1 -> table=0xFFFF, ones=16.
REQ-031 s = team PoS function S(x,y,w,z) (1 at M=2,4,7,11,12) -> table=0x1894, ones=5; repeat with SWEEP_DOWN=1 -> same result, first driven {x,y,w,z}=1111.
REQ-032 s = x, with SCAN_SETTLE_EN defined -> table=0xFF00, ones=8, done in cycle 33, busy high for 32 cycles.
REQ-033 Reset asserted in RUN cycle 5 -> outputs go to their reset values immediately, no done pulse; the next start yields a complete, correct sweep.
REQ-034 start held high throughout RUN -> single sweep, one done pulse; a new sweep begins only if start is high in IDLE after DONE.
